// File: rtl/conv_frame_sequencer.sv
// Run controller for the binary 3x3 convolution engine: loads the weight word once, then
// walks the input SRAM frame by frame, streaming row words to the datapath until the end marker.
module conv_frame_sequencer #(
    parameter logic [15:0] END_MARKER = 16'h00FF,
    parameter logic [15:0] MIN_DIM    = 16'd3,
    parameter logic [15:0] MAX_DIM    = 16'd16,
    parameter logic [11:0] WGT_ADDR   = 12'd1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        dut_run,
    output logic        dut_busy,
    output logic [11:0] dut_sram_read_address,
    input  logic [15:0] sram_dut_read_data,
    output logic [11:0] dut_wmem_read_address,
    input  logic [15:0] wmem_dut_read_data,
    output logic        weights_load,
    output logic [8:0]  weights_data,
    output logic        frame_start,
    output logic [4:0]  frame_ncols,
    output logic [11:0] out_base_addr,
    output logic        row_valid,
    input  logic        row_ready,
    output logic [15:0] row_data,
    output logic        row_last,
    input  logic        frame_done,
    output logic        dim_error
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_W_RD = 4'd1, S_W_LD = 4'd2, S_HR = 4'd3, S_HC = 4'd4,
        S_RF   = 4'd5, S_RV   = 4'd6, S_FD   = 4'd7, S_DONE = 4'd8
    } state_t;

    state_t      state_r, state_s;
    logic        wait_r, wait_s;
    logic [11:0] rd_ptr_r, rd_ptr_s, out_base_r, out_base_s;
    logic [11:0] sram_addr_r, sram_addr_s, wmem_addr_r, wmem_addr_s;
    logic [15:0] nrows_r, nrows_s, row_data_r, row_data_s;
    logic [4:0]  row_cnt_r, row_cnt_s, ncols_r, ncols_s, last_cnt_s;
    logic [8:0]  weights_data_r, weights_data_s;
    logic        weights_load_r, weights_load_s, frame_start_r, frame_start_s;
    logic        row_valid_r, row_valid_s, row_last_r, row_last_s;
    logic        busy_r, busy_s, dim_error_r, dim_error_s;
    logic        unused_s;

    function automatic logic dim_illegal(input logic [15:0] dim);
        return (dim < MIN_DIM) || (dim > MAX_DIM);
    endfunction

    assign last_cnt_s = nrows_r[4:0] - 5'd1;
    assign unused_s   = ^wmem_dut_read_data[15:9];

    // Next-state and next-register computation; every memory read spends one wait cycle (wait_r)
    always_comb begin
        state_s        = state_r;
        wait_s         = wait_r;
        rd_ptr_s       = rd_ptr_r;
        out_base_s     = out_base_r;
        sram_addr_s    = sram_addr_r;
        wmem_addr_s    = wmem_addr_r;
        nrows_s        = nrows_r;
        row_data_s     = row_data_r;
        row_cnt_s      = row_cnt_r;
        ncols_s        = ncols_r;
        weights_data_s = weights_data_r;
        weights_load_s = 1'b0;
        frame_start_s  = 1'b0;
        row_valid_s    = row_valid_r;
        row_last_s     = row_last_r;
        busy_s         = busy_r;
        dim_error_s    = dim_error_r;
        case (state_r)
            S_IDLE: begin
                if (dut_run) begin
                    state_s     = S_W_RD;
                    wmem_addr_s = WGT_ADDR;
                    rd_ptr_s    = 12'd0;
                    out_base_s  = 12'd0;
                    dim_error_s = 1'b0;
                    busy_s      = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            S_W_RD: begin
                state_s = S_W_LD;
            end
            S_W_LD: begin
                weights_data_s = wmem_dut_read_data[8:0];
                weights_load_s = 1'b1;
                sram_addr_s    = rd_ptr_r;
                wait_s         = 1'b1;
                state_s        = S_HR;
            end
            S_HR: begin
                if (wait_r) begin
                    wait_s = 1'b0;
                end else if (sram_dut_read_data == END_MARKER) begin
                    state_s = S_DONE;
                end else begin
                    nrows_s     = sram_dut_read_data;
                    rd_ptr_s    = rd_ptr_r + 12'd1;
                    sram_addr_s = rd_ptr_r + 12'd1;
                    wait_s      = 1'b1;
                    state_s     = S_HC;
                end
            end
            S_HC: begin
                if (wait_r) begin
                    wait_s = 1'b0;
                end else if (dim_illegal(nrows_r) || dim_illegal(sram_dut_read_data)) begin
                    dim_error_s = 1'b1;
                    state_s     = S_DONE;
                end else begin
                    ncols_s       = sram_dut_read_data[4:0];
                    rd_ptr_s      = rd_ptr_r + 12'd1;
                    sram_addr_s   = rd_ptr_r + 12'd1;
                    frame_start_s = 1'b1;
                    row_cnt_s     = 5'd0;
                    wait_s        = 1'b1;
                    state_s       = S_RF;
                end
            end
            S_RF: begin
                if (wait_r) begin
                    wait_s = 1'b0;
                end else begin
                    row_data_s  = sram_dut_read_data;
                    row_valid_s = 1'b1;
                    row_last_s  = (row_cnt_r == last_cnt_s);
                    state_s     = S_RV;
                end
            end
            S_RV: begin
                if (row_ready) begin
                    row_valid_s = 1'b0;
                    row_last_s  = 1'b0;
                    rd_ptr_s    = rd_ptr_r + 12'd1;
                    row_cnt_s   = row_cnt_r + 5'd1;
                    if (row_cnt_r == last_cnt_s) begin
                        state_s = S_FD;
                    end else begin
                        sram_addr_s = rd_ptr_r + 12'd1;
                        wait_s      = 1'b1;
                        state_s     = S_RF;
                    end
                end else begin
                    state_s = S_RV;
                end
            end
            S_FD: begin
                // Output rows per frame are nrows-2; nrows is already known legal here.
                if (frame_done) begin
                    out_base_s  = out_base_r + ({7'd0, nrows_r[4:0]} - 12'd2);
                    sram_addr_s = rd_ptr_r;
                    wait_s      = 1'b1;
                    state_s     = S_HR;
                end else begin
                    state_s = S_FD;
                end
            end
            S_DONE: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
            default: begin
                busy_s      = 1'b0;
                row_valid_s = 1'b0;
                row_last_s  = 1'b0;
                wait_s      = 1'b0;
                state_s     = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_r        <= S_IDLE;
            wait_r         <= 1'b0;
            rd_ptr_r       <= 12'd0;
            out_base_r     <= 12'd0;
            sram_addr_r    <= 12'd0;
            wmem_addr_r    <= 12'd0;
            nrows_r        <= 16'd0;
            row_data_r     <= 16'd0;
            row_cnt_r      <= 5'd0;
            ncols_r        <= 5'd0;
            weights_data_r <= 9'd0;
            weights_load_r <= 1'b0;
            frame_start_r  <= 1'b0;
            row_valid_r    <= 1'b0;
            row_last_r     <= 1'b0;
            busy_r         <= 1'b0;
            dim_error_r    <= 1'b0;
        end else begin
            state_r        <= state_s;
            wait_r         <= wait_s;
            rd_ptr_r       <= rd_ptr_s;
            out_base_r     <= out_base_s;
            sram_addr_r    <= sram_addr_s;
            wmem_addr_r    <= wmem_addr_s;
            nrows_r        <= nrows_s;
            row_data_r     <= row_data_s;
            row_cnt_r      <= row_cnt_s;
            ncols_r        <= ncols_s;
            weights_data_r <= weights_data_s;
            weights_load_r <= weights_load_s;
            frame_start_r  <= frame_start_s;
            row_valid_r    <= row_valid_s;
            row_last_r     <= row_last_s;
            busy_r         <= busy_s;
            dim_error_r    <= dim_error_s;
        end
    end

    assign dut_busy              = busy_r;
    assign dut_sram_read_address = sram_addr_r;
    assign dut_wmem_read_address = wmem_addr_r;
    assign weights_load          = weights_load_r;
    assign weights_data          = weights_data_r;
    assign frame_start           = frame_start_r;
    assign frame_ncols           = ncols_r;
    assign out_base_addr         = out_base_r;
    assign row_valid             = row_valid_r;
    assign row_data              = row_data_r;
    assign row_last              = row_last_r;
    assign dim_error             = dim_error_r;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: single-frame header table plus hand-written
// multi-frame, stall, reset-abort and end-only sequences against synchronous-read memories.
module tb_conv_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset_b, dut_run, dut_busy, weights_load, frame_start;
    logic        row_valid, row_ready, row_last, frame_done, dim_error;
    logic [11:0] dut_sram_read_address, dut_wmem_read_address, out_base_addr;
    logic [15:0] sram_dut_read_data, wmem_dut_read_data, row_data;
    logic [8:0]  weights_data;
    logic [4:0]  frame_ncols;

    logic [15:0] sram [0:63];
    logic [15:0] wmem [0:3];

    int tests = 0;
    int fails = 0;

    logic [15:0] rq[$];
    bit          lq[$];
    int fs_cnt, wl_cnt, wdata, busy_cyc, stable_err, dim_at_start;
    int fs_ncols [4];
    int fs_base  [4];

    typedef struct {
        int nrows;
        int ncols;
        bit stall;
        bit exp_err;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    conv_frame_sequencer dut (
        .clk(clk), .reset_b(reset_b), .dut_run(dut_run), .dut_busy(dut_busy),
        .dut_sram_read_address(dut_sram_read_address), .sram_dut_read_data(sram_dut_read_data),
        .dut_wmem_read_address(dut_wmem_read_address), .wmem_dut_read_data(wmem_dut_read_data),
        .weights_load(weights_load), .weights_data(weights_data), .frame_start(frame_start),
        .frame_ncols(frame_ncols), .out_base_addr(out_base_addr), .row_valid(row_valid),
        .row_ready(row_ready), .row_data(row_data), .row_last(row_last),
        .frame_done(frame_done), .dim_error(dim_error)
    );

    // One-cycle-latency memories
    always @(posedge clk) begin
        sram_dut_read_data <= sram[dut_sram_read_address[5:0]];
        wmem_dut_read_data <= wmem[dut_wmem_read_address[1:0]];
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_sram();
        for (int i = 0; i < 64; i++) sram[i] = 16'h0000;
    endtask

    // Runs one image; the datapath side is modelled at the falling edge.
    task automatic run_image(input bit stall, input bit spur);
        int fd_cnt;
        bit seen_busy, pend, done;
        logic [15:0] pdata;
        rq.delete(); lq.delete();
        fs_cnt = 0; wl_cnt = 0; wdata = 0; busy_cyc = 0; stable_err = 0; dim_at_start = -1;
        fd_cnt = 0; seen_busy = 1'b0; pend = 1'b0; done = 1'b0; pdata = 16'h0000;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            if (dut_busy && !seen_busy) begin
                seen_busy = 1'b1;
                dim_at_start = int'(dim_error);
            end
            if (dut_busy) busy_cyc++;
            if (weights_load) begin
                wl_cnt++;
                wdata = int'(weights_data);
            end
            if (frame_start && fs_cnt < 4) begin
                fs_ncols[fs_cnt] = int'(frame_ncols);
                fs_base[fs_cnt]  = int'(out_base_addr);
                fs_cnt++;
            end
            if (pend && (!row_valid || row_data !== pdata)) stable_err++;
            if (seen_busy && !dut_busy) done = 1'b1;
            dut_run   = (cyc == 0) || (spur && dut_busy && (cyc % 5 == 0));
            row_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            frame_done = 1'b0;
            if (fd_cnt > 0) begin
                fd_cnt--;
                if (fd_cnt == 0) frame_done = 1'b1;
            end else if (spur && row_valid && !row_ready) begin
                frame_done = 1'b1;
            end
            if (row_valid && row_ready) begin
                rq.push_back(row_data);
                lq.push_back(row_last);
                if (row_last) fd_cnt = 2;
                pend = 1'b0;
            end else begin
                pend  = row_valid;
                pdata = row_data;
            end
        end
        dut_run = 1'b0; row_ready = 1'b0; frame_done = 1'b0;
        if (!done) check("run_timeout", 0, 1);
    endtask

    initial begin
        reset_b = 1'b0; dut_run = 1'b0; row_ready = 1'b0; frame_done = 1'b0;
        wmem[0] = 16'h0055; wmem[1] = 16'hFFA5; wmem[2] = 16'h0000; wmem[3] = 16'h0000;
        clear_sram();
        vecs[0] = '{4, 5, 1'b0, 1'b0};
        vecs[1] = '{3, 3, 1'b1, 1'b0};
        vecs[2] = '{16, 16, 1'b1, 1'b0};
        vecs[3] = '{3, 2, 1'b0, 1'b1};
        vecs[4] = '{17, 4, 1'b0, 1'b1};
        vecs[5] = '{2, 8, 1'b0, 1'b1};
        vecs[6] = '{3, 16, 1'b0, 1'b0};
        repeat (3) @(negedge clk);
        check("reset_flags", int'({dut_busy, weights_load, frame_start, row_valid, row_last, dim_error}), 0);
        check("reset_addrs", int'({dut_sram_read_address, dut_wmem_read_address, out_base_addr}), 0);
        check("reset_data", int'({row_data, weights_data, frame_ncols}), 0);
        reset_b = 1'b1;

        // Single-frame header table
        for (int v = 0; v < 7; v++) begin
            clear_sram();
            sram[0] = 16'(vecs[v].nrows);
            sram[1] = 16'(vecs[v].ncols);
            for (int r = 0; r < vecs[v].nrows; r++) sram[2 + r] = 16'hA000 | 16'(2 + r);
            sram[2 + vecs[v].nrows] = 16'h00FF;
            run_image(vecs[v].stall, 1'b0);
            check($sformatf("v%0d_dim_error", v), int'(dim_error), int'(vecs[v].exp_err));
            check($sformatf("v%0d_dim_cleared", v), dim_at_start, 0);
            check($sformatf("v%0d_weights", v), wdata, 32'h1A5);
            check($sformatf("v%0d_wload_cnt", v), wl_cnt, 1);
            check($sformatf("v%0d_frames", v), fs_cnt, vecs[v].exp_err ? 0 : 1);
            check($sformatf("v%0d_rows", v), rq.size(), vecs[v].exp_err ? 0 : vecs[v].nrows);
            if (!vecs[v].exp_err) begin
                check($sformatf("v%0d_ncols", v), fs_ncols[0], vecs[v].ncols);
                check($sformatf("v%0d_base", v), fs_base[0], 0);
                check($sformatf("v%0d_base_after", v), int'(out_base_addr), vecs[v].nrows - 2);
                check($sformatf("v%0d_stable", v), stable_err, 0);
                for (int r = 0; r < rq.size(); r++) begin
                    check($sformatf("v%0d_row%0d", v, r), int'(rq[r]), 32'hA000 + 2 + r);
                    check($sformatf("v%0d_last%0d", v, r), int'(lq[r]), int'(r == vecs[v].nrows - 1));
                end
            end
        end

        // End-only image
        clear_sram();
        sram[0] = 16'h00FF;
        run_image(1'b0, 1'b0);
        check("endonly_wload", wl_cnt, 1);
        check("endonly_wdata", wdata, 32'h1A5);
        check("endonly_busy_ge4", int'(busy_cyc >= 4), 1);
        check("endonly_frames", fs_cnt, 0);
        check("endonly_rows", rq.size(), 0);
        check("endonly_err", int'(dim_error), 0);

        // Two frames (3x3 then 6x16) with stalls, spurious frame_done and run-while-busy
        clear_sram();
        sram[0] = 16'd3; sram[1] = 16'd3;
        for (int a = 2; a <= 4; a++) sram[a] = 16'hA000 | 16'(a);
        sram[5] = 16'd6; sram[6] = 16'd16;
        for (int a = 7; a <= 12; a++) sram[a] = 16'hA000 | 16'(a);
        sram[13] = 16'h00FF;
        run_image(1'b1, 1'b1);
        check("two_wload", wl_cnt, 1);
        check("two_frames", fs_cnt, 2);
        check("two_base0", fs_base[0], 0);
        check("two_base1", fs_base[1], 1);
        check("two_ncols0", fs_ncols[0], 3);
        check("two_ncols1", fs_ncols[1], 16);
        check("two_base_end", int'(out_base_addr), 5);
        check("two_stable", stable_err, 0);
        check("two_rows", rq.size(), 9);
        for (int r = 0; r < rq.size(); r++) begin
            check($sformatf("two_row%0d", r), int'(rq[r]), 32'hA000 + ((r < 3) ? 2 + r : 4 + r));
            check($sformatf("two_last%0d", r), int'(lq[r]), int'(r == 2 || r == 8));
        end

        // Reset while a row is being offered
        clear_sram();
        sram[0] = 16'd4; sram[1] = 16'd5;
        for (int a = 2; a <= 5; a++) sram[a] = 16'hA000 | 16'(a);
        sram[6] = 16'h00FF;
        @(negedge clk); dut_run = 1'b1;
        @(negedge clk); dut_run = 1'b0; row_ready = 1'b0;
        for (int i = 0; i < 50 && !row_valid; i++) @(negedge clk);
        check("rst_rv_seen", int'(row_valid), 1);
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        check("rst_flags", int'({dut_busy, weights_load, frame_start, row_valid, row_last, dim_error}), 0);
        check("rst_addrs", int'({dut_sram_read_address, dut_wmem_read_address, out_base_addr}), 0);
        check("rst_data", int'({row_data, weights_data, frame_ncols}), 0);
        repeat (3) @(negedge clk);
        check("rst_idle", int'(dut_busy), 0);
        run_image(1'b0, 1'b0);
        check("rst_rerun_rows", rq.size(), 4);
        if (rq.size() > 0) check("rst_rerun_row0", int'(rq[0]), 32'hA002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
